// File: rtl/pb_pkg.sv
// pb_pkg: shared definitions for the push-button event path.
//   pb_event_state_t      - gesture classifier state encoding
//   PB_LONG_PRESS_DEFAULT - default hold length (cycles) for a long press
//   PB_DBL_GAP_DEFAULT    - default release-to-press window (cycles) for a double click
//   pb_max()              - helper for sizing counters from the two thresholds
package pb_pkg;

   typedef enum logic [2:0] {
      StIdle          = 3'd0,
      StPressed       = 3'd1,
      StLongHeld      = 3'd2,
      StWaitSecond    = 3'd3,
      StSecondPressed = 3'd4
   } pb_event_state_t;

   localparam int unsigned PB_LONG_PRESS_DEFAULT = 50_000_000;
   localparam int unsigned PB_DBL_GAP_DEFAULT    = 12_500_000;

   function automatic int unsigned pb_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pb_edge_detect.sv
// pb_edge_detect: one-cycle history register on an active-low button level plus
// edge strobes. Reusable by any consumer of the debounced button.
//   clk   in  clock
//   rst   in  synchronous active-high reset; history resets to "unpressed"
//   pb_in in  debounced button level, 1 = unpressed, 0 = pressed
//   pb_q  out registered copy of pb_in
//   rise  out combinational: button released this cycle (0 -> 1)
//   fall  out combinational: button pressed this cycle (1 -> 0)
module pb_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic pb_in,
   output logic pb_q,
   output logic rise,
   output logic fall
);

   // Resetting to 1 makes a button held through reset appear as a fresh press.
   always_ff @(posedge clk) begin
      if (rst) begin
         pb_q <= 1'b1;
      end else begin
         pb_q <= pb_in;
      end
   end

   assign fall = pb_q & ~pb_in;
   assign rise = ~pb_q & pb_in;

endmodule

// File: rtl/pb_event_detect.sv
// pb_event_detect: classifies a debounced active-low button into single-cycle events.
//   clk           in  clock
//   rst           in  synchronous active-high reset
//   pb_in         in  debounced button level, 1 = unpressed, 0 = pressed
//   pressed       out registered level, 1 while held
//   press_pulse   out one-cycle pulse per press
//   release_pulse out one-cycle pulse per release
//   short_click   out one-cycle pulse for a completed single click
//   double_click  out one-cycle pulse for a completed double click
//   long_press    out one-cycle pulse when the hold reaches LONG_PRESS_CYCLES
// Both thresholds must be >= 2; CNT_WIDTH is derived and must not be overridden.
// Build option: define PB_EVENT_DOUBLE_CLICK_EN to enable double-click detection.
// Without it a short click is reported together with its release and double_click is 0.
module pb_event_detect
   import pb_pkg::*;
#(
   parameter int unsigned LONG_PRESS_CYCLES       = PB_LONG_PRESS_DEFAULT,
   parameter int unsigned DOUBLE_CLICK_GAP_CYCLES = PB_DBL_GAP_DEFAULT,
   parameter int unsigned CNT_WIDTH               =
      $clog2(pb_max(LONG_PRESS_CYCLES, DOUBLE_CLICK_GAP_CYCLES) + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_in,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_click,
   output logic double_click,
   output logic long_press
);

   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
`ifdef PB_EVENT_DOUBLE_CLICK_EN
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(DOUBLE_CLICK_GAP_CYCLES - 1);
`endif

   logic            pb_q;
   logic            rise;
   logic            fall;
   pb_event_state_t state;
   logic [CNT_WIDTH-1:0] cnt;

   pb_edge_detect u_edge (
      .clk   (clk),
      .rst   (rst),
      .pb_in (pb_in),
      .pb_q  (pb_q),
      .rise  (rise),
      .fall  (fall)
   );

   // pb_q is already a register of the sampled level, so this is a registered output.
   assign pressed = ~pb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_click   <= 1'b0;
         long_press    <= 1'b0;
`ifdef PB_EVENT_DOUBLE_CLICK_EN
         double_click  <= 1'b0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_click   <= 1'b0;
         long_press    <= 1'b0;
`ifdef PB_EVENT_DOUBLE_CLICK_EN
         double_click  <= 1'b0;
`endif
         // Saturate so a very long hold in LongHeld can never wrap into a match.
         if (cnt != '1) begin
            cnt <= cnt + CNT_WIDTH'(1);
         end

         case (state)
            StIdle: begin
               if (fall) begin
                  press_pulse <= 1'b1;
                  state       <= StPressed;
                  cnt         <= '0;
               end
            end

            // Release is tested first so it wins over the long threshold.
            StPressed: begin
               if (rise) begin
                  release_pulse <= 1'b1;
                  cnt           <= '0;
`ifdef PB_EVENT_DOUBLE_CLICK_EN
                  state         <= StWaitSecond;
`else
                  short_click   <= 1'b1;
                  state         <= StIdle;
`endif
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= StLongHeld;
                  cnt        <= '0;
               end
            end

            StLongHeld: begin
               if (rise) begin
                  release_pulse <= 1'b1;
                  state         <= StIdle;
                  cnt           <= '0;
               end
            end

`ifdef PB_EVENT_DOUBLE_CLICK_EN
            // A press on the expiry cycle still counts as the second press.
            StWaitSecond: begin
               if (fall) begin
                  press_pulse <= 1'b1;
                  state       <= StSecondPressed;
                  cnt         <= '0;
               end else if (cnt == GAP_LAST) begin
                  short_click <= 1'b1;
                  state       <= StIdle;
                  cnt         <= '0;
               end
            end

            // Holding the second press too long drops the pending first click.
            StSecondPressed: begin
               if (rise) begin
                  release_pulse <= 1'b1;
                  double_click  <= 1'b1;
                  state         <= StIdle;
                  cnt           <= '0;
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= StLongHeld;
                  cnt        <= '0;
               end
            end
`endif

            default: begin
               state <= StIdle;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifndef PB_EVENT_DOUBLE_CLICK_EN
   assign double_click = 1'b0;
`endif

endmodule

// File: tb/tb_pb_event_detect.sv
`timescale 1ns/1ps
module tb_pb_event_detect;

   localparam int unsigned L = 8;
   localparam int unsigned G = 5;
`ifdef PB_EVENT_DOUBLE_CLICK_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif
   localparam int MAXN = 256;
   localparam int BIG  = 1 << 20;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic pb_in = 1'b1;
   logic pressed, press_pulse, release_pulse, short_click, double_click, long_press;

   pb_event_detect #(
      .LONG_PRESS_CYCLES       (L),
      .DOUBLE_CLICK_GAP_CYCLES (G)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pb_in         (pb_in),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_click   (short_click),
      .double_click  (double_click),
      .long_press    (long_press)
   );

   always #5 clk = ~clk;

   // Episode stimulus: lvl[t] = 1 means the button is held for sample t after reset.
   bit lvl [MAXN];
   int n;
   // Expected pulses per sample index, derived from gesture rules.
   bit e_pp [MAXN];
   bit e_rp [MAXN];
   bit e_sc [MAXN];
   bit e_dc [MAXN];
   bit e_lp [MAXN];

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   int cur      = 0;

   function automatic void chk(input string name, input int t, input logic act, input bit exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%b expected=%b", name, t, act, exp);
      end
   endfunction

   function automatic void chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endfunction

   function automatic void mark(input int which, input int t);
      if (t >= 0 && t < n) begin
         case (which)
            0: e_sc[t] = 1'b1;
            1: e_dc[t] = 1'b1;
            default: e_lp[t] = 1'b1;
         endcase
      end
   endfunction

   // Gesture-level model: pair each press with its release, then classify by hold
   // length and by the distance from a release to the following press.
   function automatic void build_model();
      int ps[$];
      int rs[$];
      int i;
      for (int t = 0; t < MAXN; t++) begin
         e_pp[t] = 1'b0; e_rp[t] = 1'b0; e_sc[t] = 1'b0; e_dc[t] = 1'b0; e_lp[t] = 1'b0;
      end
      for (int t = 0; t < n; t++) begin
         e_pp[t] = lvl[t] && (t == 0 || !lvl[t-1]);
         e_rp[t] = !lvl[t] && t > 0 && lvl[t-1];
         if (e_pp[t]) ps.push_back(t);
         if (e_rp[t]) rs.push_back(t);
      end
      if (rs.size() < ps.size()) rs.push_back(BIG);
      i = 0;
      while (i < ps.size()) begin
         if (rs[i] - ps[i] > int'(L)) begin
            mark(2, ps[i] + int'(L));
            i++;
         end else if (!DBL) begin
            mark(0, rs[i]);
            i++;
         end else if (i + 1 < ps.size() && ps[i+1] - rs[i] <= int'(G)) begin
            if (rs[i+1] - ps[i+1] > int'(L)) mark(2, ps[i+1] + int'(L));
            else                             mark(1, rs[i+1]);
            i += 2;
         end else begin
            mark(0, rs[i] + int'(G));
            i++;
         end
      end
   endfunction

   function automatic int first_evt(input int which);
      for (int t = 0; t < n; t++) begin
         case (which)
            0: if (e_sc[t]) return t;
            1: if (e_dc[t]) return t;
            2: if (e_lp[t]) return t;
            default: if (e_pp[t]) return t;
         endcase
      end
      return -1;
   endfunction

   task automatic add_run(input bit lv, input int len);
      for (int i = 0; i < len; i++) begin
         if (n < MAXN) begin
            lvl[n] = lv;
            n++;
         end
      end
   endtask

   // Single compare process: cur = -1 checks the reset state, otherwise sample cur.
   always @(negedge clk) begin
      if (chk_en) begin
         if (cur < 0) begin
            chk("rst_pressed", cur, pressed, 1'b0);
            chk("rst_press_pulse", cur, press_pulse, 1'b0);
            chk("rst_release_pulse", cur, release_pulse, 1'b0);
            chk("rst_short_click", cur, short_click, 1'b0);
            chk("rst_double_click", cur, double_click, 1'b0);
            chk("rst_long_press", cur, long_press, 1'b0);
         end else begin
            chk("pressed", cur, pressed, lvl[cur]);
            chk("press_pulse", cur, press_pulse, e_pp[cur]);
            chk("release_pulse", cur, release_pulse, e_rp[cur]);
            chk("short_click", cur, short_click, e_sc[cur]);
            chk("double_click", cur, double_click, e_dc[cur]);
            chk("long_press", cur, long_press, e_lp[cur]);
         end
      end
   end

   // Reset (with pb_in already at the episode's opening level), then play lvl[0..n-1].
   task automatic run_episode();
      build_model();
      @(negedge clk);
      rst   = 1'b1;
      pb_in = ~lvl[0];
      @(posedge clk);
      cur    = -1;
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < n; t++) begin
         if (t > 0) @(negedge clk);
         pb_in = ~lvl[t];
         @(posedge clk);
         cur = t;
      end
      @(negedge clk);
      #1 chk_en = 1'b0;
   endtask

   initial begin
      // Short click: press 3, release.
      n = 0; add_run(0, 2); add_run(1, 3); add_run(0, 12);
      run_episode();
      chk_int("pin_e1_short", first_evt(0), DBL ? 10 : 5);
      chk_int("pin_e1_double", first_evt(1), -1);

      // Double click: press 2, release 2, press 2, release.
      n = 0; add_run(0, 2); add_run(1, 2); add_run(0, 2); add_run(1, 2); add_run(0, 12);
      run_episode();
      chk_int("pin_e2_double", first_evt(1), DBL ? 8 : -1);
      chk_int("pin_e2_short", first_evt(0), DBL ? -1 : 4);

      // Long press: held 20.
      n = 0; add_run(0, 1); add_run(1, 20); add_run(0, 10);
      run_episode();
      chk_int("pin_e3_long", first_evt(2), 9);
      chk_int("pin_e3_short", first_evt(0), -1);

      // Release exactly on the long threshold cycle: short path.
      n = 0; add_run(0, 1); add_run(1, 8); add_run(0, 10);
      run_episode();
      chk_int("pin_e4_long", first_evt(2), -1);
      chk_int("pin_e4_short", first_evt(0), DBL ? 14 : 9);

      // Second press exactly on the gap expiry cycle: double path.
      n = 0; add_run(0, 1); add_run(1, 2); add_run(0, 5); add_run(1, 2); add_run(0, 10);
      run_episode();
      chk_int("pin_e5_double", first_evt(1), DBL ? 10 : -1);

      // Reset during the gap window, then idle: no stale short_click.
      n = 0; add_run(0, 1); add_run(1, 2); add_run(0, 2);
      run_episode();
      n = 0; add_run(0, 12);
      run_episode();
      chk_int("pin_e7_short", first_evt(0), -1);

      // Button held through reset: press_pulse on the first sample.
      n = 0; add_run(1, 3); add_run(0, 10);
      run_episode();
      chk_int("pin_e8_press", first_evt(3), 0);

      // Randomized gestures; some episodes end without settling so reset aborts them.
      for (int ep = 0; ep < 40; ep++) begin
         int k;
         n = 0;
         add_run(0, $urandom_range(0, 3));
         k = $urandom_range(1, 6);
         for (int g = 0; g < k; g++) begin
            add_run(1, $urandom_range(1, 11));
            add_run(0, $urandom_range(1, 8));
         end
         if ($urandom_range(0, 3) != 0) add_run(0, 12);
         run_episode();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pb_event_detect.md
# pb_event_detect

Button gesture classifier placed directly downstream of the push-button debouncer. Consumes the debounced, active-low button level and emits single-cycle event pulses: press, release, short click, double click and long press. Feeds UART command and control logic, which act only on classified events and never on the raw button level.

## Interface
- LONG_PRESS_CYCLES, 50_000_000: cycles the button must be held after press_pulse before long_press fires; must be ≥ 2.
- DOUBLE_CLICK_GAP_CYCLES, 12_500_000: maximum cycles from release_pulse to a second press for that press to count as a double click; must be ≥ 2.
- CNT_WIDTH, $clog2(max(LONG_PRESS_CYCLES, DOUBLE_CLICK_GAP_CYCLES)+1): derived; do not override.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- pb_in  in  1  debounced button level, already synchronous to clk; 1 = unpressed, 0 = pressed.
- pressed  out  1  registered level, 1 while the button is held.
- press_pulse  out  1  one-cycle pulse on each press.
- release_pulse  out  1  one-cycle pulse on each release.
- short_click  out  1  one-cycle pulse for a completed single click.
- double_click  out  1  one-cycle pulse for a completed double click.
- long_press  out  1  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES.

## Operation
- pb_q samples pb_in every cycle. fall = pb_q & ~pb_in; rise = ~pb_q & pb_in.
- Reset:
  - state = IDLE, cnt = 0, pb_q = 1.
  - All outputs are 0.
  - If the button is held through reset, press_pulse is produced on the first sample after reset.
- FSM states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED. cnt clears on every state entry and increments each cycle the state is held.
- IDLE:
  - fall → PRESSED; assert press_pulse.
- PRESSED:
  - rise → assert release_pulse. Go to WAIT_SECOND (double-click compiled in) or assert short_click and go to IDLE (compiled out).
  - Still pressed with cnt == LONG_PRESS_CYCLES-1 → assert long_press, go to LONG_HELD.
- LONG_HELD:
  - rise → assert release_pulse, go to IDLE. No click event is generated.
- WAIT_SECOND:
  - fall → assert press_pulse, go to SECOND_PRESSED.
  - cnt == DOUBLE_CLICK_GAP_CYCLES-1 with no fall → assert short_click, go to IDLE.
- SECOND_PRESSED:
  - rise → assert release_pulse and double_click, go to IDLE.
  - Reaching LONG_PRESS_CYCLES-1 → assert long_press, go to LONG_HELD. The pending first click is discarded.
- Simultaneous events:
  - A release on the cycle the long threshold is hit counts as a release (short path).
  - A press on the cycle the gap expires counts as a press (double path).
- cnt never wraps; it is compared with == only against values below its range limit.
- At most one of short_click / double_click / long_press is asserted per cycle.

## Timing
- Latency: an edge first sampled at clock edge k drives its pulse and pressed during the cycle following edge k, i.e. a registered 1-cycle latency.
- long_press is asserted exactly LONG_PRESS_CYCLES cycles after press_pulse.
- short_click (double-click compiled in) is asserted exactly DOUBLE_CLICK_GAP_CYCLES cycles after release_pulse.
- short_click (double-click compiled out) is asserted in the same cycle as release_pulse.
- All pulses are exactly one cycle wide.
- A reset asserted mid-gesture aborts it: no pending event is ever emitted.

## Configuration
- PB_EVENT_DOUBLE_CLICK_EN defined:
  - WAIT_SECOND and SECOND_PRESSED exist.
  - short_click is delayed by the gap window.
- Macro undefined:
  - Those two states are removed and double_click is tied to 0.
  - short_click coincides with release_pulse.
  - The DOUBLE_CLICK_GAP_CYCLES parameter is ignored.

## Structure
- Shared package pb_pkg holds:
  - typedef enum logic [2:0] pb_event_state_t.
  - Default threshold constants PB_LONG_PRESS_DEFAULT and PB_DBL_GAP_DEFAULT.
- Sub-module pb_edge_detect: the pb_q register plus rise/fall generation. It is reusable by other button consumers.

## Test plan
All scenarios use LONG_PRESS_CYCLES=8, DOUBLE_CLICK_GAP_CYCLES=5, macro defined unless stated.
- Press held 3 cycles, then release → press_pulse, release_pulse, then short_click 5 cycles after release_pulse; no double_click.
- Press 2 cycles, release 2 cycles, press 2 cycles, release → double_click together with the second release_pulse; no short_click at any point.
- Press held 20 cycles → long_press 8 cycles after press_pulse; release_pulse on release; no click pulses.
- Boundary cases:
  - Release on the exact cycle cnt reaches 7 → short path, no long_press.
  - Second press on the exact cycle the gap cnt reaches 4 → double_click on its release.
- Reset asserted in WAIT_SECOND → all outputs 0 and no short_click after reset. Button held through reset → press_pulse on the first sample after reset.
- Macro undefined, press 3 cycles then release → short_click in the same cycle as release_pulse; double_click stays 0 throughout.
